mod53_weight_remover: RTL and testbench
=======================================

Name: mod53_weight_remover

Overview:
- Sequential inverse of the mod-53 chunk-weighting LUTs. Those LUTs map a 6-bit chunk to chunk·64^k mod 53.
- This block takes a weighted residue r and a chunk index k, and returns r·64^(−k) mod 53, where 64^(−1) ≡ 29 (mod 53).
- It uses LSB-first square-and-multiply, with a valid/ready handshake on both sides.
- It sits on the decode side of the x_500 modular datapath, recovering unweighted chunk residues for checking and reconstruction.

Parameters:
- MOD, 53, modulus. Must be prime and < 2^W.
- W, 6, residue width.
- KW, 7, width of chunk index k. Covers 0..127, which includes chunks 0..83 of a 500-bit operand.
- INV_BASE, 29, value of 2^(−W) mod MOD.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_r  in  W  weighted residue. Values ≥ MOD are pre-reduced by a single subtraction of MOD.
- in_k  in  KW  chunk index.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x  out  W  unweighted residue, always < MOD.

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low, and is the only reset.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_x = 0.
  - Internal acc, base, kreg and cnt are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: acc ← (in_r ≥ MOD ? in_r − MOD : in_r); base ← INV_BASE; kreg ← in_k; cnt ← 0; state → RUN.
  - Without in_valid, stay in IDLE.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge: if kreg[0] then acc ← (acc·base) mod MOD; base ← (base·base) mod MOD; kreg ← kreg >> 1; cnt ← cnt + 1.
  - When cnt = KW−1 at the edge, the step completes and state → DONE.
- Exactly KW RUN edges are taken for every k, including k = 0. Latency is fixed: out_valid rises KW+1 edges after the accepting edge.
- DONE:
  - out_valid = 1 and out_x = acc. Both are registered and stable while waiting.
  - On an edge with out_ready: out_valid → 0, state → IDLE.
  - in_ready stays low in DONE, so no accept can occur in the same cycle as the output handshake.
  - Throughput: one result per KW+2 cycles minimum.
- Modular multiply is combinational:
  - Form the 2W-bit product (max 52·52 = 2704).
  - Reduce mod MOD with a single-cycle reduction, e.g. the quotient estimate q = floor(p·⌊2^(2W+…)/MOD⌋) followed by ≤2 conditional subtractions, or a 12→6 LUT.
  - The result is always < MOD. No carry beyond 2W bits.
- Inputs are ignored outside IDLE. in_r/in_k need only be stable on the accepting edge.
- out_ready outside DONE is ignored.
- Reset asserted mid-RUN or in DONE immediately returns to the reset values. The result in flight is discarded; no partial output is ever presented.
- in_r = 0 yields 0 for any k. Since 29^52 ≡ 1 (Fermat), k and k+52 give identical results.

Test Plan:
1. Reset, then request r=1, k=1 → out_x=29, with out_valid first high exactly KW+1=8 edges after the accept.
2. r=11, k=1 → 1. Then r=1, k=2 → 46. Then r=15, k=2 → 1, confirming it inverts 11^2 ≡ 15.
3. r=52, k=0 → 52. Then r=60 (out of range), k=0 → 7. Then r=0, k=127 → 0. Latency is still 8 for each.
4. r=5, k=52 → 5, and r=5, k=104 → 5 (Fermat wrap). Compare every k in 0..127 against a reference model for all r in 0..52.
5. Hold out_ready=0 for 10 cycles in DONE → out_valid/out_x stable and in_ready=0. Raise out_ready → IDLE next edge, and a back-to-back in_valid is accepted on the following edge.
6. Deassert rst_n asynchronously at cnt=3 of RUN → outputs return to reset values immediately. After release, a new request (r=1, k=1) returns 29 with no stale data.

Source files
------------

// File: rtl/mod53_weight_remover.sv
// Removes the chunk weight 64^k from a mod-53 residue: out_x = r * 29^k mod 53.
// LSB-first square-and-multiply over a fixed KW steps, valid/ready on both sides.
`timescale 1ns/1ps
module mod53_weight_remover #(
  parameter int MOD      = 53,
  parameter int W        = 6,
  parameter int KW       = 7,
  parameter int INV_BASE = 29
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_r,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_x
);

  localparam int PW = 2 * W;
  localparam int SH = 2 * W + 6;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  localparam logic [W-1:0]  MOD_W    = W'(MOD);
  localparam logic [PW-1:0] MOD_P    = PW'(MOD);
  localparam logic [PW:0]   MOD_Q    = (PW + 1)'(MOD);
  localparam logic [W-1:0]  INV_W    = W'(INV_BASE);
  localparam logic [SH:0]   BM       = (SH + 1)'((1 << SH) / MOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(KW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  base_q, base_d;
  logic [KW-1:0] kreg_q, kreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_x_q, out_x_d;

  // Barrett reduction: the quotient estimate is at most one short, so two
  // conditional subtractions always land the result below MOD.
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0]    p;
    logic [PW+SH:0]   t;
    logic [PW:0]      q;
    logic [PW-1:0]    qm;
    logic [PW-1:0]    r;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t  = {{(SH + 1){1'b0}}, p} * {{PW{1'b0}}, BM};
    q  = (PW + 1)'(t >> SH);
    qm = PW'(q * MOD_Q);
    r  = p - qm;
    if (r >= MOD_P) r = r - MOD_P;
    if (r >= MOD_P) r = r - MOD_P;
    return W'(r);
  endfunction

  function automatic logic [W-1:0] reduce_in(input logic [W-1:0] r);
    return (r >= MOD_W) ? (r - MOD_W) : r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      base_q      <= '0;
      kreg_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      kreg_q      <= kreg_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    out_x_d = out_x_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = reduce_in(in_r);
          base_d  = INV_W;
          kreg_d  = in_k;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (kreg_q[0]) acc_d = mulmod(acc_q, base_q);
        base_d = mulmod(base_q, base_q);
        kreg_d = kreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // Every k walks all KW bits so latency never depends on the operand.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          out_x_d = acc_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    out_x     = out_x_q;
  end

endmodule

// File: tb/tb_mod53_weight_remover.sv
// Bench for mod53_weight_remover: directed cases, exhaustive r/k sweep,
// random requests, back-pressure and asynchronous reset mid-computation.
`timescale 1ns/1ps
module tb_mod53_weight_remover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_r;
  logic [6:0] in_k;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_x;

  int errors = 0;
  int checks = 0;
  int lat;
  int exp_x;
  int rr, kk;

  mod53_weight_remover dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x)
  );

  always #5 clk = ~clk;

  // Reference: reduce r once, then divide by 64 (multiply by 29) k times.
  function automatic int ref_x(input int r, input int k);
    int x;
    x = (r >= 53) ? r - 53 : r;
    for (int i = 0; i < k; i++) x = (x * 29) % 53;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Presents a request once in_ready is seen; returns #1 after the accepting edge.
  task automatic send(input int r, input int k);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_r     = r[5:0];
    in_k     = k[6:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges with the accepting edge as edge 1.
  task automatic wait_done(output int l);
    l = 1;
    while (out_valid !== 1'b1 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input int r, input int k, input int expv);
    send(r, k);
    wait_done(lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_x"}, out_x, expv);
    take();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_k = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn("r1k1", 1, 1, 29);
    txn("r11k1", 11, 1, 1);
    txn("r1k2", 1, 2, 46);
    txn("r15k2", 15, 2, 1);
    txn("r52k0", 52, 0, 52);
    txn("r60k0", 60, 0, 7);
    txn("r0k127", 0, 127, 0);
    txn("r5k52", 5, 52, 5);
    txn("r5k104", 5, 104, 5);

    for (int k = 0; k < 128; k++)
      for (int r = 0; r < 53; r++)
        txn("sweep", r, k, ref_x(r, k));

    for (int i = 0; i < 150; i++) begin
      rr = $urandom_range(63, 0);
      kk = $urandom_range(127, 0);
      txn("rand", rr, kk, ref_x(rr, kk));
    end

    // Back-pressure: hold the result, with a competing request pending.
    exp_x = ref_x(7, 3);
    send(7, 3);
    wait_done(lat);
    check("hold_lat", lat, 8);
    in_valid = 1'b1; in_r = 6'd1; in_k = 7'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_x", out_x, exp_x);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accepted", in_ready, 0);
    wait_done(lat);
    check("b2b_lat", lat, 8);
    check("b2b_x", out_x, 29);
    take();

    // Asynchronous reset three steps into RUN.
    send(11, 5);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_x", out_x, 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 0);
    txn("post_rst", 1, 1, 29);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
